// File: rtl/test_pattern_checker.sv
// test_pattern_checker: per-frame verdict on a tagged test-pattern pixel stream.
// Define TPC_FIRST_ERR_CAPTURE_EN to add first-mismatch coordinate outputs.
module test_pattern_checker #(
  parameter int HRES  = 1280,
  parameter int VRES  = 720,
  parameter int ERR_W = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    enable_in,
  input  logic [1:0]              sel_in,
  input  logic                    valid_in,
  input  logic [$clog2(HRES)-1:0] hcount_in,
  input  logic [$clog2(VRES)-1:0] vcount_in,
  input  logic [7:0]              red_in,
  input  logic [7:0]              green_in,
  input  logic [7:0]              blue_in,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic                    frame_pass_out,
  output logic [ERR_W-1:0]        err_count_out,
  output logic [15:0]             frames_checked_out
`ifdef TPC_FIRST_ERR_CAPTURE_EN
  ,
  output logic [$clog2(HRES)-1:0] first_err_h_out,
  output logic [$clog2(VRES)-1:0] first_err_v_out,
  output logic                    first_err_valid_out
`endif
);

  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);
  localparam int PW = $clog2(HRES*VRES+1);
  localparam logic [PW-1:0] FULL = PW'(HRES*VRES);

  typedef enum logic [1:0] {
    IDLE, SYNC, CHECK, REPORT
  } state_t;

  state_t state, state_nx;

  logic          s1_vld;
  logic [1:0]    s1_sel;
  logic [HW-1:0] s1_hc;
  logic [VW-1:0] s1_vc;
  logic [7:0]    s1_r, s1_g, s1_b;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_vld <= 1'b0;
      s1_sel <= '0;
      s1_hc  <= '0;
      s1_vc  <= '0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= valid_in & enable_in;
      s1_sel <= sel_in;
      s1_hc  <= hcount_in;
      s1_vc  <= vcount_in;
      s1_r   <= red_in;
      s1_g   <= green_in;
      s1_b   <= blue_in;
    end
  end

  logic [31:0]      hx, vx;
  logic [5:0]       h6, v6, s6;
  logic [1:0]       mode, m;
  logic [7:0]       er, eg, eb;
  logic             mis, at_org, at_end;
  logic             start, acc, fin, brk, run;
  logic [ERR_W-1:0] err, err_acc, d_err;
  logic [PW-1:0]    cnt, cnt_acc;
  logic             d_pass;

  assign hx = 32'(s1_hc);
  assign vx = 32'(s1_vc);
  assign h6 = hx[5:0];
  assign v6 = vx[5:0];
  assign s6 = h6 + v6;
  assign at_org = s1_vld && hx == 0 && vx == 0;
  assign at_end = s1_vld && hx == 32'(HRES-1)
                         && vx == 32'(VRES-1);
  // the frame-opening pixel is judged by the mode it carries
  assign m = start ? s1_sel : mode;

  always_comb begin
    er = 8'h00;
    eg = 8'h00;
    eb = 8'h00;
    unique case (m)
      2'd0: begin
        er = 8'hff;
        eb = 8'hff;
      end
      2'd1: begin
        if (vx == 32'(VRES/2) || hx == 32'(HRES/2)) begin
          er = 8'hff;
          eg = 8'hff;
          eb = 8'hff;
        end
      end
      2'd2: begin
        er = {h6, 2'b00};
        eg = {h6, 2'b00};
        eb = {h6, 2'b00};
      end
      2'd3: begin
        er = {h6, 2'b00};
        eg = {v6, 2'b00};
        eb = {s6, 2'b00};
      end
    endcase
    mis = (s1_r != er) || (s1_g != eg) || (s1_b != eb)
       || (hx >= 32'(HRES)) || (vx >= 32'(VRES));
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    acc      = 1'b0;
    fin      = 1'b0;
    brk      = 1'b0;
    if (!enable_in) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nx = SYNC;
        SYNC: begin
          if (at_org) begin
            start    = 1'b1;
            state_nx = CHECK;
          end
        end
        CHECK: begin
          if (at_org) begin
            brk      = 1'b1;
            start    = 1'b1;
            state_nx = REPORT;
          end else if (at_end) begin
            acc      = 1'b1;
            fin      = 1'b1;
            state_nx = REPORT;
          end else begin
            acc = s1_vld;
          end
        end
        REPORT: begin
          // run: a restart already opened the next frame
          if (run) begin
            acc      = s1_vld;
            state_nx = CHECK;
          end else if (at_org) begin
            start    = 1'b1;
            state_nx = CHECK;
          end else begin
            state_nx = SYNC;
          end
        end
      endcase
    end
  end

  assign err_acc = &err ? err : err + ERR_W'(mis);
  assign cnt_acc = &cnt ? cnt : cnt + PW'(1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= IDLE;
      run    <= 1'b0;
      mode   <= '0;
      err    <= '0;
      cnt    <= '0;
      d_err  <= '0;
      d_pass <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= brk;
      if (fin) begin
        d_err  <= err_acc;
        d_pass <= err_acc == '0 && cnt_acc == FULL;
      end else if (brk) begin
        d_err  <= err;
        d_pass <= 1'b0;
      end
      if (!enable_in) begin
        err <= '0;
        cnt <= '0;
      end else if (start) begin
        err  <= ERR_W'(mis);
        cnt  <= PW'(1);
        mode <= s1_sel;
      end else if (acc) begin
        err <= err_acc;
        cnt <= cnt_acc;
      end
    end
  end

`ifdef TPC_FIRST_ERR_CAPTURE_EN
  logic [HW-1:0] fe_h, d_fe_h;
  logic [VW-1:0] fe_v, d_fe_v;
  logic          fe_vld, d_fe_vld;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fe_h     <= '0;
      fe_v     <= '0;
      fe_vld   <= 1'b0;
      d_fe_h   <= '0;
      d_fe_v   <= '0;
      d_fe_vld <= 1'b0;
    end else begin
      if (fin) begin
        d_fe_vld <= fe_vld | mis;
        d_fe_h   <= fe_vld ? fe_h : s1_hc;
        d_fe_v   <= fe_vld ? fe_v : s1_vc;
      end else if (brk) begin
        d_fe_vld <= fe_vld;
        d_fe_h   <= fe_h;
        d_fe_v   <= fe_v;
      end
      if (!enable_in) begin
        fe_vld <= 1'b0;
      end else if (start) begin
        fe_vld <= mis;
        fe_h   <= s1_hc;
        fe_v   <= s1_vc;
      end else if (acc && mis && !fe_vld) begin
        fe_vld <= 1'b1;
        fe_h   <= s1_hc;
        fe_v   <= s1_vc;
      end
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_done_out     <= 1'b0;
      frame_pass_out     <= 1'b0;
      err_count_out      <= '0;
      frames_checked_out <= '0;
`ifdef TPC_FIRST_ERR_CAPTURE_EN
      first_err_h_out     <= '0;
      first_err_v_out     <= '0;
      first_err_valid_out <= 1'b0;
`endif
    end else begin
      frame_done_out <= 1'b0;
      if (state == REPORT && enable_in) begin
        frame_done_out     <= 1'b1;
        frame_pass_out     <= d_pass;
        err_count_out      <= d_err;
        frames_checked_out <= frames_checked_out + 16'd1;
`ifdef TPC_FIRST_ERR_CAPTURE_EN
        first_err_h_out     <= d_fe_h;
        first_err_v_out     <= d_fe_v;
        first_err_valid_out <= d_fe_vld;
`endif
      end
    end
  end

  assign busy_out = state == SYNC || state == CHECK;

endmodule

// File: tb/tb_test_pattern_checker.sv
// tb_test_pattern_checker: directed bench on a reduced 40x6 raster.
// Second instance uses a 4-bit error counter for saturation.
module tb_test_pattern_checker;

  localparam int HR = 40;
  localparam int VR = 6;

  logic       clk = 1'b0;
  logic       rst_n, en, valid;
  logic [1:0] sel;
  logic [5:0] hc;
  logic [2:0] vc;
  logic [7:0] r, g, b;

  logic        busy, done, pass;
  logic [15:0] err, frames;
  logic        busy4, done4, pass4;
  logic [3:0]  err4;
  logic [15:0] frames4;
`ifdef TPC_FIRST_ERR_CAPTURE_EN
  logic [5:0] feh, feh4;
  logic [2:0] fev, fev4;
  logic       fevld, fevld4;
`endif

  int checks = 0;
  int errors = 0;
  int nd = 0;
  logic rp [0:31];
  int   re [0:31];

  always #5 clk = ~clk;

  test_pattern_checker #(.HRES(HR), .VRES(VR), .ERR_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en),
    .sel_in(sel), .valid_in(valid),
    .hcount_in(hc), .vcount_in(vc),
    .red_in(r), .green_in(g), .blue_in(b),
    .busy_out(busy), .frame_done_out(done),
    .frame_pass_out(pass), .err_count_out(err),
    .frames_checked_out(frames)
`ifdef TPC_FIRST_ERR_CAPTURE_EN
    , .first_err_h_out(feh), .first_err_v_out(fev),
    .first_err_valid_out(fevld)
`endif
  );

  test_pattern_checker #(.HRES(HR), .VRES(VR), .ERR_W(4)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en),
    .sel_in(sel), .valid_in(valid),
    .hcount_in(hc), .vcount_in(vc),
    .red_in(r), .green_in(g), .blue_in(b),
    .busy_out(busy4), .frame_done_out(done4),
    .frame_pass_out(pass4), .err_count_out(err4),
    .frames_checked_out(frames4)
`ifdef TPC_FIRST_ERR_CAPTURE_EN
    , .first_err_h_out(feh4), .first_err_v_out(fev4),
    .first_err_valid_out(fevld4)
`endif
  );

  always @(negedge clk) begin
    if (done && nd < 32) begin
      rp[nd] = pass;
      re[nd] = 32'(err);
      nd++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] col(input int m,
                                      input int h,
                                      input int v);
    logic [5:0] a, c, s;
    a = 6'(h);
    c = 6'(v);
    s = a + c;
    case (m)
      0: return 24'hff00ff;
      1: return (v == VR/2 || h == HR/2) ? 24'hffffff : 24'h0;
      2: return {a, 2'b00, a, 2'b00, a, 2'b00};
      default: return {a, 2'b00, c, 2'b00, s, 2'b00};
    endcase
  endfunction

  task automatic send_px(input int h, input int v,
                         input logic [23:0] c);
    valid = 1'b1;
    hc = 6'(h);
    vc = 3'(v);
    {r, g, b} = c;
    @(negedge clk);
  endtask

  task automatic send_frame(input int m, input int n,
                            input int bh, input int bv,
                            input bit blk, input int sw,
                            input int xt);
    logic [23:0] c;
    sel = 2'(m);
    for (int i = 0; i < n; i++) begin
      int h, v;
      h = i % HR;
      v = i / HR;
      if (i == sw) sel = 2'd3;
      if (i == xt) send_px(45, 1, col(m, 45, 1));
      c = blk ? 24'h0 : col(m, h, v);
      if (h == bh && v == bv) c = 24'h0;
      send_px(h, v, c);
    end
  endtask

  task automatic finish_frame(input string tag);
    int lat;
    valid = 1'b0;
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sel = '0;
    valid = 1'b0;
    hc = '0;
    vc = '0;
    {r, g, b} = 24'h0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("sync_busy", 32'(busy), 32'd1);

    send_px(5, 2, 24'h123456);
    send_frame(3, 240, -1, -1, 0, -1, -1);
    finish_frame("m3");
    chk("m3_pass", 32'(pass), 32'd1);
    chk("m3_err", 32'(err), 32'd0);
    chk("m3_frames", 32'(frames), 32'd1);
    chk("m3_ndone", 32'(nd), 32'd1);

    send_frame(1, 240, 10, 3, 0, -1, -1);
    finish_frame("m1");
    chk("m1_pass", 32'(pass), 32'd0);
    chk("m1_err", 32'(err), 32'd1);
    chk("m1_frames", 32'(frames), 32'd2);
`ifdef TPC_FIRST_ERR_CAPTURE_EN
    chk("m1_feh", 32'(feh), 32'd10);
    chk("m1_fev", 32'(fev), 32'd3);
    chk("m1_fevld", 32'(fevld), 32'd1);
`endif

    n0 = nd;
    send_frame(2, 220, -1, -1, 0, -1, -1);
    send_frame(2, 240, -1, -1, 0, -1, -1);
    finish_frame("short");
    chk("short_ndone", 32'(nd - n0), 32'd2);
    chk("short_pass", 32'(rp[n0]), 32'd0);
    chk("short_err", 32'(re[n0]), 32'd0);
    chk("short_next_pass", 32'(rp[n0+1]), 32'd1);
    chk("short_frames", 32'(frames), 32'd4);

    n0 = nd;
    send_frame(0, 240, -1, -1, 0, 100, -1);
    send_frame(3, 240, -1, -1, 0, -1, -1);
    finish_frame("selsw");
    chk("selsw_ndone", 32'(nd - n0), 32'd2);
    chk("selsw_pass0", 32'(rp[n0]), 32'd1);
    chk("selsw_pass1", 32'(rp[n0+1]), 32'd1);
    chk("selsw_frames", 32'(frames), 32'd6);

    n0 = nd;
    send_frame(0, 91, -1, -1, 0, -1, -1);
    valid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ndone", 32'(nd - n0), 32'd0);
    chk("abort_frames", 32'(frames), 32'd6);
    en = 1'b1;
    @(negedge clk);
    send_frame(0, 240, -1, -1, 0, -1, -1);
    finish_frame("reen");
    chk("reen_ndone", 32'(nd - n0), 32'd1);
    chk("reen_pass", 32'(pass), 32'd1);
    chk("reen_frames", 32'(frames), 32'd7);

    send_frame(0, 240, -1, -1, 1, -1, -1);
    finish_frame("black");
    chk("black_err16", 32'(err), 32'd240);
    chk("black_err4", 32'(err4), 32'd15);
    chk("black_pass4", 32'(pass4), 32'd0);
    chk("black_pass", 32'(pass), 32'd0);
    chk("black_frames", 32'(frames), 32'd8);

    send_frame(2, 240, -1, -1, 0, -1, 50);
    finish_frame("range");
    chk("range_pass", 32'(pass), 32'd0);
    chk("range_err", 32'(err), 32'd1);
    chk("range_frames", 32'(frames), 32'd9);

    send_frame(0, 30, -1, -1, 0, -1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_frames", 32'(frames), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_err4", 32'(err4), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
